// File: rtl/vga_arb_pkg.sv
// Shared types and default constants for the VGA/SDRAM arbiter slice.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DISP_ISSUE = 2'd1,
    DISP_DRAIN = 2'd2,
    WRITE      = 2'd3
  } arb_state_t;

  localparam int unsigned FB_WORDS_DEFAULT  = 640 * 480;
  localparam int unsigned BURST_LEN_DEFAULT = 16;
  localparam int unsigned LOW_WATER_DEFAULT = 128;

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Wrapping framebuffer read-address counter for display refill bursts.
module vga_fetch_addr_gen #(
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned FB_BASE  = 0,
  parameter int unsigned FB_WORDS = vga_arb_pkg::FB_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              reload,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_BASE + FB_WORDS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= BASE;
    end else if (reload) begin
      addr <= BASE;
    end else if (inc) begin
      addr <= (addr == LAST) ? BASE : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/vga_sdram_arbiter.sv
// Arbitrates the SDRAM Avalon master between VGA refill bursts and a single-word writer.
// Optional writer starvation guard: define VGA_ARB_STARVE_GUARD_EN.
module vga_sdram_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_LVL_W   = 10,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned BURST_LEN    = BURST_LEN_DEFAULT,
  parameter int unsigned LOW_WATER    = LOW_WATER_DEFAULT,
  parameter int unsigned FB_BASE      = 0,
  parameter int unsigned FB_WORDS     = FB_WORDS_DEFAULT,
  parameter int unsigned MAX_DISP_RUN = 4
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [FIFO_LVL_W-1:0] fifo_level,
  output logic                  fifo_wr,
  output logic [DATA_W-1:0]     fifo_wdata,
  output logic                  fifo_clr,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ack,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest
);

  localparam int unsigned PW = $clog2(BURST_LEN) + 1;
  localparam logic [FIFO_LVL_W-1:0] LOW_LVL  = FIFO_LVL_W'(LOW_WATER);
  localparam logic [FIFO_LVL_W-1:0] ROOM_LVL = FIFO_LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [PW-1:0]         LAST_RD  = PW'(BURST_LEN - 1);

  arb_state_t state, state_nxt;

  logic [PW-1:0]     issue_cnt;
  logic [PW-1:0]     pend_cnt;
  logic              frame_pend;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] disp_addr;

  logic rd_acc;
  logic beat;
  logic urgent;
  logic room;
  logic clr;
  logic latch_wr;
  logic urgent_grant;
  logic force_wr;

  assign urgent = (fifo_level < LOW_LVL);
  assign room   = (fifo_level <= ROOM_LVL);
  assign rd_acc = (state == DISP_ISSUE) && !avm_waitrequest;
  // Beats with nothing outstanding (e.g. stale returns after a reset) are dropped here.
  assign beat   = avm_readdatavalid && (pend_cnt != '0);

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int unsigned RW = $clog2(MAX_DISP_RUN + 1);
  logic [RW-1:0] run_cnt;

  assign force_wr = wr_req && (run_cnt == RW'(MAX_DISP_RUN));

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (latch_wr) begin
      run_cnt <= '0;
    end else if (urgent_grant && wr_req && (run_cnt != RW'(MAX_DISP_RUN))) begin
      run_cnt <= run_cnt + RW'(1);
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    clr          = 1'b0;
    latch_wr     = 1'b0;
    urgent_grant = 1'b0;
    case (state)
      IDLE: begin
        if (frame_pend) begin
          clr = 1'b1;
        end else if (urgent && !force_wr) begin
          state_nxt    = DISP_ISSUE;
          urgent_grant = 1'b1;
        end else if (wr_req) begin
          state_nxt = WRITE;
          latch_wr  = 1'b1;
        end else if (room) begin
          state_nxt = DISP_ISSUE;
        end
      end
      DISP_ISSUE: if (rd_acc && (issue_cnt == LAST_RD)) state_nxt = DISP_DRAIN;
      DISP_DRAIN: if (pend_cnt == '0) state_nxt = IDLE;
      WRITE:      if (!avm_waitrequest) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      pend_cnt   <= '0;
      frame_pend <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state      <= state_nxt;
      frame_pend <= frame_start | (frame_pend & ~clr);
      if (latch_wr) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      if (rd_acc) begin
        issue_cnt <= (issue_cnt == LAST_RD) ? '0 : issue_cnt + PW'(1);
      end
      case ({rd_acc, beat})
        2'b10:   pend_cnt <= pend_cnt + PW'(1);
        2'b01:   pend_cnt <= pend_cnt - PW'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  vga_fetch_addr_gen #(
    .ADDR_W   (ADDR_W),
    .FB_BASE  (FB_BASE),
    .FB_WORDS (FB_WORDS)
  ) u_addr_gen (
    .clk    (clk50),
    .rst_n  (rst_n),
    .inc    (rd_acc),
    .reload (clr),
    .addr   (disp_addr)
  );

  assign avm_read      = (state == DISP_ISSUE);
  assign avm_write     = (state == WRITE);
  assign wr_ack        = (state == WRITE) && !avm_waitrequest;
  assign avm_address   = avm_read  ? disp_addr :
                         avm_write ? wr_addr_q : '0;
  assign avm_writedata = avm_write ? wr_data_q : '0;
  assign fifo_clr      = clr;
  assign fifo_wr       = beat;
  assign fifo_wdata    = beat ? avm_readdata : '0;

endmodule

// File: tb/tb_vga_sdram_arbiter.sv
// Scoreboard bench for vga_sdram_arbiter with a latency-3 Avalon slave model.
module tb_vga_sdram_arbiter;

  localparam int unsigned FBW = 40;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  fifo_level = 10'd512;
  logic        fifo_wr;
  logic [31:0] fifo_wdata;
  logic        fifo_clr;
  logic        wr_req = 1'b0;
  logic [24:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic [24:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest = 1'b0;

  vga_sdram_arbiter #(
    .ADDR_W       (25),
    .DATA_W       (32),
    .FIFO_LVL_W   (10),
    .FIFO_DEPTH   (512),
    .BURST_LEN    (16),
    .LOW_WATER    (128),
    .FB_BASE      (0),
    .FB_WORDS     (FBW),
    .MAX_DISP_RUN (4)
  ) dut (
    .clk50             (clk50),
    .rst_n             (rst_n),
    .frame_start       (frame_start),
    .fifo_level        (fifo_level),
    .fifo_wr           (fifo_wr),
    .fifo_wdata        (fifo_wdata),
    .fifo_clr          (fifo_clr),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ack            (wr_ack),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [31:0] data;
    int          due;
  } ret_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0, wr_cnt = 0, ack_cnt = 0, clr_cnt = 0;
  int ack_at_acc = 0, clr_at_acc = 0;
  logic [24:0] ack_addr;
  logic [31:0] ack_data;
  bit stall = 0, toggle_en = 1;
  int unsigned model = 0;

  ret_t        ret_q[$];
  logic [24:0] acc_q[$];
  int          acc_cyc_q[$];
  logic [31:0] got_q[$];
  logic [24:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  function automatic logic [31:0] pix(input logic [24:0] a);
    return {7'h35, a} ^ 32'h0F0F_0000;
  endfunction

  // Avalon slave: returns pix(addr) three cycles after each accepted read.
  initial begin
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(posedge clk50); #1;
      cyc++;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      if (!stall && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = ret_q[0].data;
        void'(ret_q.pop_front());
      end else if (toggle_en && cyc[0]) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = '1;
      end
    end
  end

  // Event recorder, sampled mid-cycle.
  initial forever begin
    @(negedge clk50);
    if (avm_read && !avm_waitrequest) begin
      acc_q.push_back(avm_address);
      acc_cyc_q.push_back(cyc);
      acc_cnt++;
      ret_q.push_back('{data: pix(avm_address), due: cyc + 3});
    end
    if (fifo_wr) begin
      got_q.push_back(fifo_wdata);
      wr_cnt++;
    end
    if (wr_ack) begin
      ack_cnt++;
      ack_at_acc = acc_cnt;
      ack_addr = avm_address;
      ack_data = avm_writedata;
    end
    if (fifo_clr) begin
      clr_cnt++;
      clr_at_acc = acc_cnt;
    end
  end

  task automatic step();
    @(negedge clk50); #1;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(25'(model));
      exp_data_q.push_back(pix(25'(model)));
      model = (model == FBW - 1) ? 0 : model + 1;
    end
  endtask

  task automatic wait_for(input int kind, input int target, input string what);
    bit ok;
    ok = 0;
    for (int n = 0; n < 10000 && !ok; n++) begin
      step();
      case (kind)
        0: ok = (acc_cnt >= target);
        1: ok = (wr_cnt >= target);
        2: ok = avm_read;
        3: ok = avm_write;
        default: ok = 1;
      endcase
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s acc=%0d fifo_wr=%0d target=%0d", what, acc_cnt, wr_cnt, target);
    end
  endtask

  task automatic test_reset();
    logic [93:0] outs;
    for (int i = 0; i < 5; i++) begin
      step();
      outs = {avm_read, avm_write, fifo_wr, fifo_clr, wr_ack, avm_address, avm_writedata, fifo_wdata};
      checks++;
      if (outs !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, outs);
      end
    end
    rst_n = 1'b1;
    toggle_en = 0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (wr_cnt !== 0 || avm_read !== 1'b0 || avm_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_quiet fifo_wr_count=%0d read=%b write=%b want 0 0 0", wr_cnt, avm_read, avm_write);
    end
  endtask

  task automatic test_urgent_burst();
    int base;
    logic [24:0] ga; logic [31:0] gd; logic [24:0] ea; logic [31:0] ed;
    base = acc_cnt;
    push_exp(16);
    fifo_level = 10'd10;
    wait_for(2, 0, "urgent_start");
    fifo_level = 10'd512;
    wait_for(0, base + 16, "urgent_reads");
    wait_for(1, base + 16, "urgent_fifo");
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (acc_cyc_q.size() >= base + 16 && acc_cyc_q[base + 15] - acc_cyc_q[base] !== 15) begin
      failures++;
      $display("FAIL back_to_back span=%0d want=15", acc_cyc_q[base + 15] - acc_cyc_q[base]);
    end
    checks++;
    if (avm_read !== 1'b0 || wr_cnt !== base + 16) begin
      failures++;
      $display("FAIL urgent_idle read=%b fifo_wr_count=%0d want 0 %0d", avm_read, wr_cnt, base + 16);
    end
    while (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ga = (acc_q.size() != 0) ? acc_q.pop_front() : 'x;
      gd = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ga !== ea || gd !== ed) begin
        failures++;
        $display("FAIL urgent_read got addr=%0d data=%h want addr=%0d data=%h", ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_arbitration();
    int base;
    base = acc_cnt;
    @(posedge clk50); #1;
    avm_waitrequest = 1'b1;
    step();
    fifo_level = 10'd300;
    wr_req = 1'b1;
    wr_addr = 25'h1234;
    wr_data = 32'hCAFE_F00D;
    wait_for(3, 0, "write_start");
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (avm_address !== 25'h1234 || avm_writedata !== 32'hCAFE_F00D || wr_ack !== 1'b0 || avm_write !== 1'b1) begin
        failures++;
        $display("FAIL write_hold cycle=%0d got addr=%h data=%h ack=%b want 1234 cafef00d 0", k, avm_address, avm_writedata, wr_ack);
      end
      @(posedge clk50); #1;
      if (k == 4) avm_waitrequest = 1'b0;
      step();
    end
    checks++;
    if (wr_ack !== 1'b1 || avm_write !== 1'b1 || avm_address !== 25'h1234) begin
      failures++;
      $display("FAIL write_ack cycle5 got ack=%b write=%b addr=%h want 1 1 1234", wr_ack, avm_write, avm_address);
    end
    wr_req = 1'b0;
    fifo_level = 10'd512;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (ack_cnt !== 1 || acc_cnt !== base) begin
      failures++;
      $display("FAIL write_first ack_count=%0d reads=%0d want 1 %0d", ack_cnt, acc_cnt - base, 0);
    end
  endtask

  task automatic test_wrap_frame();
    int base, clr_base;
    logic [24:0] ga; logic [31:0] gd; logic [24:0] ea; logic [31:0] ed;
    base = acc_cnt;
    push_exp(32);
    fifo_level = 10'd10;
    wait_for(0, base + 32, "wrap_reads");
    fifo_level = 10'd512;
    wait_for(1, wr_cnt + (acc_cnt - base) - (wr_cnt - base) , "wrap_fifo");
    wait_for(1, base + 32, "wrap_fifo2");
    checks++;
    if (acc_q.size() >= 25 && (acc_q[23] !== 25'd39 || acc_q[24] !== 25'd0)) begin
      failures++;
      $display("FAIL wrap_point got %0d,%0d want 39,0", acc_q[23], acc_q[24]);
    end
    base = acc_cnt;
    clr_base = clr_cnt;
    push_exp(16);
    model = 0;
    push_exp(16);
    fifo_level = 10'd10;
    wait_for(2, 0, "frame_burst");
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_for(0, base + 16, "frame_first");
    checks++;
    if (clr_cnt !== clr_base) begin
      failures++;
      $display("FAIL clr_mid_burst count=%0d want=%0d", clr_cnt - clr_base, 0);
    end
    wait_for(0, base + 32, "frame_second");
    fifo_level = 10'd512;
    wait_for(1, base + 32, "frame_fifo");
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (clr_cnt !== clr_base + 1 || clr_at_acc !== base + 16) begin
      failures++;
      $display("FAIL fifo_clr count=%0d at_read=%0d want 1 %0d", clr_cnt - clr_base, clr_at_acc - base, 16);
    end
    while (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ga = (acc_q.size() != 0) ? acc_q.pop_front() : 'x;
      gd = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ga !== ea || gd !== ed) begin
        failures++;
        $display("FAIL wrap_frame_read got addr=%0d data=%h want addr=%0d data=%h", ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_read_stall();
    int base;
    bit prev_hold;
    logic [24:0] prev_addr;
    logic [24:0] ga; logic [31:0] gd; logic [24:0] ea; logic [31:0] ed;
    base = acc_cnt;
    prev_hold = 0;
    prev_addr = '0;
    push_exp(16);
    fifo_level = 10'd10;
    for (int n = 0; n < 400 && acc_cnt < base + 16; n++) begin
      @(posedge clk50); #1;
      avm_waitrequest = 1'($urandom_range(0, 1));
      step();
      if (acc_cnt > base) fifo_level = 10'd512;
      if (prev_hold) begin
        checks++;
        if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
          failures++;
          $display("FAIL read_hold got read=%b addr=%0d want 1 %0d", avm_read, avm_address, prev_addr);
        end
      end
      prev_hold = avm_read && avm_waitrequest;
      prev_addr = avm_address;
    end
    @(posedge clk50); #1;
    avm_waitrequest = 1'b0;
    fifo_level = 10'd512;
    wait_for(1, base + 16, "stall_fifo");
    for (int i = 0; i < 4; i++) step();
    while (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ga = (acc_q.size() != 0) ? acc_q.pop_front() : 'x;
      gd = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ga !== ea || gd !== ed) begin
        failures++;
        $display("FAIL stall_read got addr=%0d data=%h want addr=%0d data=%h", ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_starve();
    int base, nreads, ack_base;
    logic [24:0] ga; logic [31:0] gd; logic [24:0] ea; logic [31:0] ed;
    base = acc_cnt;
    ack_base = ack_cnt;
`ifdef VGA_ARB_STARVE_GUARD_EN
    nreads = 64;
`else
    nreads = 320;
`endif
    push_exp(nreads);
    wr_addr = 25'h55;
    wr_data = 32'h1357_9BDF;
    wr_req = 1'b1;
    fifo_level = 10'd0;
`ifdef VGA_ARB_STARVE_GUARD_EN
    for (int n = 0; n < 3000 && ack_cnt == ack_base; n++) step();
    wr_req = 1'b0;
    fifo_level = 10'd512;
    checks++;
    if (ack_cnt !== ack_base + 1 || ack_at_acc !== base + 64 || ack_addr !== 25'h55 || ack_data !== 32'h1357_9BDF) begin
      failures++;
      $display("FAIL guard_write acks=%0d after_reads=%0d addr=%h data=%h want 1 64 55 13579bdf", ack_cnt - ack_base, ack_at_acc - base, ack_addr, ack_data);
    end
`else
    wait_for(0, base + nreads, "starve_reads");
    wr_req = 1'b0;
    fifo_level = 10'd512;
    checks++;
    if (ack_cnt !== ack_base) begin
      failures++;
      $display("FAIL starve_no_ack acks=%0d want 0", ack_cnt - ack_base);
    end
`endif
    wait_for(1, base + nreads, "starve_fifo");
    for (int i = 0; i < 6; i++) step();
    while (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ga = (acc_q.size() != 0) ? acc_q.pop_front() : 'x;
      gd = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ga !== ea || gd !== ed) begin
        failures++;
        $display("FAIL starve_read got addr=%0d data=%h want addr=%0d data=%h", ga, gd, ea, ed);
      end
    end
  endtask

  task automatic test_reset_drain();
    int base, wbase;
    logic [24:0] ga; logic [31:0] gd;
    base = acc_cnt;
    wbase = wr_cnt;
    push_exp(16);
    stall = 1;
    fifo_level = 10'd10;
    wait_for(2, 0, "drain_start");
    fifo_level = 10'd512;
    wait_for(0, base + 16, "drain_reads");
    stall = 0;
    wait_for(1, wbase + 11, "drain_partial");
    stall = 1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    model = 0;
    stall = 0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (ret_q.size() !== 0) begin
      failures++;
      $display("FAIL drain_beats_sent left=%0d want 0", ret_q.size());
    end
    checks++;
    if (wr_cnt !== wbase + 11 || avm_read !== 1'b0) begin
      failures++;
      $display("FAIL drain_dropped fifo_wr=%0d read=%b want 11 0", wr_cnt - wbase, avm_read);
    end
    for (int i = 0; i < 16; i++) begin
      ga = (acc_q.size() != 0) ? acc_q.pop_front() : 'x;
      checks++;
      if (ga !== exp_addr_q[0]) begin
        failures++;
        $display("FAIL drain_read_addr idx=%0d got=%0d want=%0d", i, ga, exp_addr_q[0]);
      end
      if (i < 11) begin
        gd = (got_q.size() != 0) ? got_q.pop_front() : 'x;
        checks++;
        if (gd !== exp_data_q[0]) begin
          failures++;
          $display("FAIL drain_read_data idx=%0d got=%h want=%h", i, gd, exp_data_q[0]);
        end
      end
      void'(exp_addr_q.pop_front());
      void'(exp_data_q.pop_front());
    end
    base = acc_cnt;
    push_exp(16);
    fifo_level = 10'd10;
    wait_for(2, 0, "post_reset_start");
    fifo_level = 10'd512;
    wait_for(1, wbase + 27, "post_reset_fifo");
    for (int i = 0; i < 4; i++) step();
    while (exp_addr_q.size() != 0) begin
      ga = (acc_q.size() != 0) ? acc_q.pop_front() : 'x;
      gd = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      checks++;
      if (ga !== exp_addr_q[0] || gd !== exp_data_q[0]) begin
        failures++;
        $display("FAIL post_reset_read got addr=%0d data=%h want addr=%0d data=%h", ga, gd, exp_addr_q[0], exp_data_q[0]);
      end
      void'(exp_addr_q.pop_front());
      void'(exp_data_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_urgent_burst();
    test_arbitration();
    test_wrap_frame();
    test_read_stall();
    test_starve();
    test_reset_drain();
    checks++;
    if (acc_q.size() !== 0 || got_q.size() !== 0) begin
      failures++;
      $display("FAIL leftover reads=%0d fifo_words=%0d want 0 0", acc_q.size(), got_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
